frame_update_sched: RTL
=======================

Name: frame_update_sched

Overview:
- Per-frame game-logic scheduler for the pong design.
- Watches the VGA timing generator's active-low vsync and visible-range outputs. At the start of each vertical sync it sequences N game-update stages (left paddle, right paddle, ball, score) through a start/done handshake.
- Pulses a commit when all stages finish, so the renderer sees object state change only during vertical blanking.
- Detects overrun into the visible region and hung stages.

Parameters:
- N_STAGES, 4, number of update stages, started in index order 0..N_STAGES-1.
- TIMEOUT_CYCLES, 4096, maximum clk_i cycles a stage may take before being declared hung.
- FRAME_CNT_W, 16, width of the committed-frame counter.
- STAGE_IDX_W, $clog2(N_STAGES) (minimum 1), stage index width.

Ports:
- clk_i  in  1  system clock (same domain as the timing generator).
- rst_ni  in  1  reset, asynchronous, active-low.
- enable_i  in  1  allow new frame sequences to start.
- vsync_i  in  1  timing generator vsync, active-low.
- visible_i  in  1  timing generator visible range.
- stage_done_i  in  N_STAGES  per-stage completion; level or pulse.
- overrun_clr_i  in  1  clears the sticky error flags.
- stage_start_o  out  N_STAGES  one-hot, one-cycle start pulse.
- busy_o  out  1  sequence in progress.
- frame_commit_o  out  1  one-cycle pulse: all stages completed this frame.
- frame_cnt_o  out  FRAME_CNT_W  count of committed frames.
- overrun_o  out  1  sticky: visible_i rose before the sequence completed.
- timeout_o  out  1  sticky: a stage exceeded TIMEOUT_CYCLES.
- fault_stage_o  out  STAGE_IDX_W  index of the stage active at the last overrun/timeout.

Behaviour:
- Reset values:
  - Outputs: stage_start_o=0, busy_o=0, frame_commit_o=0, frame_cnt_o=0, overrun_o=0, timeout_o=0, fault_stage_o=0.
  - Internals: vsync_q=1, state=IDLE, stage index=0, timeout counter=0.
- Reset mid-sequence: everything returns to the reset values immediately; no commit.
- Frame trigger:
  - Trigger = vsync_q & ~vsync_i, i.e. the falling edge of the registered vsync, seen at cycle t.
  - Accepted only in IDLE with enable_i=1. Otherwise ignored; no pending trigger is stored.
- States:
  - IDLE
    - Waits for the trigger.
    - On trigger: stage index=0, go to START.
  - START
    - stage_start_o[idx]=1 for exactly this cycle; timeout counter cleared; go to WAIT.
    - The first start appears at cycle t+1.
  - WAIT
    - Priority: overrun > done > timeout.
    - Overrun (visible_i=1): overrun_o=1, fault_stage_o=idx, go to IDLE.
    - Done (stage_done_i[idx]=1): if idx==N_STAGES-1 go to COMMIT; else idx+1, go to START. The next start follows done by exactly 1 cycle.
    - Timeout (counter reaches TIMEOUT_CYCLES-1): timeout_o=1, fault_stage_o=idx, go to IDLE.
    - Otherwise the counter increments.
  - COMMIT
    - frame_commit_o=1 for one cycle; frame_cnt_o+1, wrapping modulo 2^FRAME_CNT_W; go to IDLE.
- Aborted frames (overrun or timeout) never commit and never increment frame_cnt_o.
- stage_done_i handling:
  - Bits other than the active stage are ignored.
  - The active bit is sampled only in WAIT, so a done asserted in the same cycle as its start is not seen until the following cycle.
  - A level-held done is therefore safe.
- busy_o = (state != IDLE); it is high from t+1 through the COMMIT cycle.
- enable_i:
  - Gates only the trigger. Deassertion mid-sequence does not abort; the current frame completes or faults normally.
- Sticky flags:
  - overrun_clr_i=1 clears overrun_o and timeout_o.
  - If a clear coincides with a new error, the set wins.
  - fault_stage_o holds its value until the next error.
- Nominal budget (640x480, 50 MHz clock, 2 clk/pixel): vsync plus back porch = 35 lines × 800 px × 2 = 56000 clk.
- All outputs are driven from registers or decoded from state registers; no combinational path from inputs to outputs.

Decomposition:
- Package frame_sched_pkg:
  - sched_state_t enum {IDLE, START, WAIT, COMMIT}.
  - Stage index constants STG_PADDLE_L=0, STG_PADDLE_R=1, STG_BALL=2, STG_SCORE=3.
  - Default TIMEOUT_CYCLES.
- One small sub-module, sync_edge_det: registers vsync_i and produces the falling-edge pulse, with async active-low reset to 1.

Test Plan:
- Nominal frame with stages completing 10/20/30/40 cycles after their start:
  - stage_start_o pulses in order 0001, 0010, 0100, 1000, each 1 cycle after the previous done.
  - frame_commit_o pulses 1 cycle after the last done; frame_cnt_o 0→1; no flags set.
- Stage 2 never completes, TIMEOUT_CYCLES=16:
  - timeout_o=1 and fault_stage_o=2 sixteen cycles after start[2]; busy_o=0; no commit; frame_cnt_o unchanged.
- visible_i raised while waiting on stage 1: overrun_o=1, fault_stage_o=1, no commit. overrun_clr_i pulse → overrun_o=0.
- enable_i=0 at the vsync edge: no start pulses. enable_i dropped during stage 1: the sequence still commits.
- frame_cnt_o at 16'hFFFF, full frame completes: frame_cnt_o wraps to 0 on commit.
- rst_ni asserted asynchronously mid-WAIT (between clock edges): all outputs reach their reset values immediately. After release, the next vsync edge starts again at stage 0.

Source files
------------

// File: rtl/frame_sched_pkg.sv
// Shared types and constants for the per-frame game-update scheduler.
// Stage indices match the order in which the scheduler starts the update engines.
package frame_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      START  = 2'd1,
      WAIT   = 2'd2,
      COMMIT = 2'd3
   } sched_state_t;

   localparam int STG_PADDLE_L = 0;
   localparam int STG_PADDLE_R = 1;
   localparam int STG_BALL     = 2;
   localparam int STG_SCORE    = 3;

   localparam int DEFAULT_N_STAGES       = 4;
   localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers a same-domain active-low strobe and flags its falling edge.
// Pulse is combinational in the cycle the input first reads low; no backpressure.
module sync_edge_det (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sig_i,
   output logic fall_o
);

   logic sig_q;

   // Resetting high means a line already low at reset release is not a new edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sig_q <= 1'b1;
      else         sig_q <= sig_i;
   end

   assign fall_o = sig_q & ~sig_i;

endmodule

// File: rtl/frame_update_sched.sv
// Sequences the game-update stages once per vsync and commits only when all finish.
// First start 1 cycle after the vsync edge, each next start 1 cycle after done; aborts on overrun/timeout.
module frame_update_sched
   import frame_sched_pkg::*;
#(
   parameter int N_STAGES       = DEFAULT_N_STAGES,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int FRAME_CNT_W    = 16,
   parameter int STAGE_IDX_W    = idx_width(N_STAGES)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   enable_i,
   input  logic                   vsync_i,
   input  logic                   visible_i,
   input  logic [N_STAGES-1:0]    stage_done_i,
   input  logic                   overrun_clr_i,
   output logic [N_STAGES-1:0]    stage_start_o,
   output logic                   busy_o,
   output logic                   frame_commit_o,
   output logic [FRAME_CNT_W-1:0] frame_cnt_o,
   output logic                   overrun_o,
   output logic                   timeout_o,
   output logic [STAGE_IDX_W-1:0] fault_stage_o
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   sched_state_t           state_q, state_d;
   logic [STAGE_IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic                   overrun_q, overrun_d;
   logic                   timeout_q, timeout_d;
   logic [STAGE_IDX_W-1:0] fault_q, fault_d;
   logic                   trig;

   sync_edge_det u_vsync_edge (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .sig_i  (vsync_i),
      .fall_o (trig)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      frame_cnt_d = frame_cnt_q;
      overrun_d   = overrun_q;
      timeout_d   = timeout_q;
      fault_d     = fault_q;

      // Clear first so an error detected this same cycle overrides it below.
      if (overrun_clr_i) begin
         overrun_d = 1'b0;
         timeout_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (trig && enable_i) begin
               idx_d   = '0;
               state_d = START;
            end
         end
         START: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (visible_i) begin
               overrun_d = 1'b1;
               fault_d   = idx_q;
               state_d   = IDLE;
            end else if (stage_done_i[idx_q]) begin
               if (idx_q == STAGE_IDX_W'(N_STAGES - 1)) begin
                  state_d = COMMIT;
               end else begin
                  idx_d   = idx_q + STAGE_IDX_W'(1);
                  state_d = START;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               timeout_d = 1'b1;
               fault_d   = idx_q;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         COMMIT: begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         frame_cnt_q <= '0;
         overrun_q   <= 1'b0;
         timeout_q   <= 1'b0;
         fault_q     <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         frame_cnt_q <= frame_cnt_d;
         overrun_q   <= overrun_d;
         timeout_q   <= timeout_d;
         fault_q     <= fault_d;
      end
   end

   always_comb begin
      stage_start_o = '0;
      if (state_q == START) stage_start_o[idx_q] = 1'b1;
   end

   assign busy_o         = (state_q != IDLE);
   assign frame_commit_o = (state_q == COMMIT);
   assign frame_cnt_o    = frame_cnt_q;
   assign overrun_o      = overrun_q;
   assign timeout_o      = timeout_q;
   assign fault_stage_o  = fault_q;

endmodule
